switch_debounce_toggle: RTL

SWITCH_DEBOUNCE_TOGGLE -- requirements
Module: switch_debounce_toggle

---
 rtl/switch_ctrl_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/switch_debounce_toggle.sv | 97 +++++++++
 3 files changed

// File: rtl/switch_ctrl_pkg.sv
// Shared definitions for the switch debounce/toggle controller.
package switch_ctrl_pkg;

  // Debounce FSM states: two settled levels and two qualification windows.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } switch_state_t;

  // Number of consecutive stable synchronized samples used when not overridden.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous bit into the clock domain.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw bit through two flops; the first may go metastable, the second settles it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_debounce_toggle.sv
// Debounces a bouncing mechanical switch, reports press/release pulses,
// keeps a press-driven toggle and counts rejected transitions.
module switch_debounce_toggle
  import switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       switch,
  output logic       switch_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       toggle_state,
  output logic [7:0] glitch_count
);

  // Terminal count of the qualification window; reaching it while the level holds accepts the change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               sync_q;
  switch_state_t      state;
  logic [CNT_W-1:0]   cnt;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (switch),
    .q     (sync_q)
  );

  // Debounce FSM with registered outputs: a level change must persist for the
  // whole window to be accepted, otherwise it is counted as a glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= STABLE_LOW;
      cnt           <= '0;
      switch_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle_state  <= 1'b0;
      glitch_count  <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (sync_q) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync_q) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            if (glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
          end else if (cnt == CNT_LAST) begin
            state        <= STABLE_HIGH;
            cnt          <= '0;
            switch_level <= 1'b1;
            press_pulse  <= 1'b1;
            toggle_state <= ~toggle_state;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!sync_q) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync_q) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
            if (glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
          end else if (cnt == CNT_LAST) begin
            state         <= STABLE_LOW;
            cnt           <= '0;
            switch_level  <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
